decode_control_unit: RTL and testbench

DECODE_CONTROL_UNIT -- requirements
Module: decode_control_unit

---
 rtl/decode_control_unit_pkg.sv | 53 +++++
 rtl/decode_control_unit_opcode_decoder.sv | 73 +++++++
 rtl/decode_control_unit.sv | 187 ++++++++++++++++++
 tb/tb_decode_control_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_control_unit_pkg.sv
`default_nettype none
// ============================================================================
// Package  : decode_control_unit_pkg
// Brief    : Shared decode constants: RV32 opcodes, immediate-format select
//            encodings, decode-control FSM state encodings and the
//            multi-cycle divide/remainder classifier. Also used by the
//            immediate generation unit.
// Revision : 1.0 - initial release
// ============================================================================
package decode_control_unit_pkg;

    // Major opcodes (instruction bits [6:0])
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_op_imm = 7'b0010011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_op     = 7'b0110011;

    // funct7 value that selects the M-extension group inside OP
    localparam logic [6:0] c_funct7_muldiv = 7'b0000001;

    // Immediate format select
    localparam logic [2:0] c_imm_u    = 3'b000;
    localparam logic [2:0] c_imm_j    = 3'b001;
    localparam logic [2:0] c_imm_i    = 3'b010;
    localparam logic [2:0] c_imm_b    = 3'b011;
    localparam logic [2:0] c_imm_s    = 3'b100;
    localparam logic [2:0] c_imm_none = 3'b111;

    // Decode-control FSM state encodings
    localparam int                    c_state_w    = 1;
    localparam logic [c_state_w-1:0]  c_st_run     = 1'b0;
    localparam logic [c_state_w-1:0]  c_st_md_wait = 1'b1;

    // Width of the divider wait-cycle counter
    localparam int c_md_cnt_w = 6;

    // DIV/DIVU/REM/REMU: OP opcode, M-extension funct7, funct3[2] set.
    // MUL* share the opcode and funct7 but have funct3[2] clear.
    function automatic logic f_is_divrem(
        input logic [6:0] opcode,
        input logic [6:0] funct7,
        input logic       funct3_msb
    );
        return (opcode == c_op_op) && (funct7 == c_funct7_muldiv) && funct3_msb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_control_unit_opcode_decoder.sv
`default_nettype none
// ============================================================================
// Module   : opcode_decoder
// Brief    : Purely combinational classification of a held instruction:
//            immediate format, operand-2 source, register/memory intent,
//            unknown-opcode flag and multi-cycle divide detection.
// Revision : 1.0 - initial release
// ============================================================================
module opcode_decoder
    import decode_control_unit_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [6:0] i_funct7,
    input  logic       i_funct3_msb,
    output logic [2:0] o_imm_sel,
    output logic       o_operand2_imm,
    output logic       o_reg_write,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_illegal,
    output logic       o_is_divrem
);

    // Map the opcode to its instruction class; unknown opcodes get no immediate
    always_comb begin
        o_imm_sel      = c_imm_none;
        o_operand2_imm = 1'b0;
        o_reg_write    = 1'b0;
        o_mem_read     = 1'b0;
        o_mem_write    = 1'b0;
        o_illegal      = 1'b0;
        case (i_opcode)
            c_op_lui, c_op_auipc: begin
                o_imm_sel      = c_imm_u;
                o_operand2_imm = 1'b1;
                o_reg_write    = 1'b1;
            end
            c_op_jal: begin
                o_imm_sel   = c_imm_j;
                o_reg_write = 1'b1;
            end
            c_op_jalr, c_op_op_imm: begin
                o_imm_sel      = c_imm_i;
                o_operand2_imm = 1'b1;
                o_reg_write    = 1'b1;
            end
            c_op_load: begin
                o_imm_sel      = c_imm_i;
                o_operand2_imm = 1'b1;
                o_reg_write    = 1'b1;
                o_mem_read     = 1'b1;
            end
            c_op_branch: begin
                o_imm_sel = c_imm_b;
            end
            c_op_store: begin
                o_imm_sel      = c_imm_s;
                o_operand2_imm = 1'b1;
                o_mem_write    = 1'b1;
            end
            c_op_op: begin
                o_reg_write = 1'b1;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

    assign o_is_divrem = f_is_divrem(i_opcode, i_funct7, i_funct3_msb);

endmodule
`default_nettype wire

// File: rtl/decode_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : decode_control_unit
// Brief    : Instruction-decode stage control. Holds the ID register,
//            decodes the held instruction and sequences multi-cycle
//            divide/remainder operations (start, wait for done, abort on
//            redirect, forced release on timeout with a sticky error).
// Revision : 1.0 - initial release
// ============================================================================
module decode_control_unit
    import decode_control_unit_pkg::*;
#(
    parameter int          MD_TIMEOUT = 40,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
)(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTRUCTION_IF,
    input  logic [31:0] PC_IF,
    input  logic        IF_VALID,
    input  logic        FLUSH,
    input  logic        LOAD_USE_HAZARD,
    input  logic        MULDIV_DONE,
    output logic [31:0] INSTRUCTION_ID,
    output logic [31:0] PC_ID,
    output logic [2:0]  IMM_SELECT,
    output logic        OPERAND2_IMM,
    output logic        REG_WRITE_EN,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic        ISSUE,
    output logic        STALL_IF,
    output logic        MULDIV_START,
    output logic        MULDIV_ABORT,
    output logic        ILLEGAL,
    output logic        MD_ERROR
);

    // Last wait-counter value before a forced release. The counter saturates
    // at its maximum, so oversized timeouts are clamped to that maximum.
    localparam int c_md_last_int = (MD_TIMEOUT > (1 << c_md_cnt_w)) ? ((1 << c_md_cnt_w) - 1) :
                                   ((MD_TIMEOUT < 1) ? 0 : (MD_TIMEOUT - 1));
    localparam logic [c_md_cnt_w-1:0] c_md_last    = c_md_cnt_w'(c_md_last_int);
    localparam logic [c_md_cnt_w-1:0] c_md_cnt_max = '1;

    logic [31:0]           r_instr_id;
    logic [31:0]           r_pc_id;
    logic                  r_valid_id;
    logic [c_state_w-1:0]  r_state;
    logic [c_state_w-1:0]  w_state_next;
    logic [c_md_cnt_w-1:0] r_md_cnt;
    logic                  r_md_error;

    logic                  w_issue;
    logic                  w_stall;
    logic                  w_start;
    logic                  w_abort;
    logic                  w_timeout_fire;
    logic                  w_md_expired;

    logic [2:0]            w_imm_sel;
    logic                  w_operand2_imm;
    logic                  w_reg_write;
    logic                  w_mem_read;
    logic                  w_mem_write;
    logic                  w_illegal;
    logic                  w_is_divrem;

    opcode_decoder u_opcode_decoder (
        .i_opcode       (r_instr_id[6:0]),
        .i_funct7       (r_instr_id[31:25]),
        .i_funct3_msb   (r_instr_id[14]),
        .o_imm_sel      (w_imm_sel),
        .o_operand2_imm (w_operand2_imm),
        .o_reg_write    (w_reg_write),
        .o_mem_read     (w_mem_read),
        .o_mem_write    (w_mem_write),
        .o_illegal      (w_illegal),
        .o_is_divrem    (w_is_divrem)
    );

    assign w_md_expired = (r_md_cnt >= c_md_last);

    // ID register: a redirect always wins, otherwise load whenever fetch is not held
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_instr_id <= NOP_INSTR;
            r_pc_id    <= 32'h0;
            r_valid_id <= 1'b0;
        end else if (FLUSH) begin
            r_instr_id <= NOP_INSTR;
            r_valid_id <= 1'b0;
        end else if (!w_stall) begin
            r_instr_id <= INSTRUCTION_IF;
            r_pc_id    <= PC_IF;
            r_valid_id <= IF_VALID;
        end
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= c_st_run;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control outputs. A redirect in RUN kills the held
    // divide, so no divider start is raised for it.
    always_comb begin
        w_state_next   = r_state;
        w_issue        = 1'b0;
        w_stall        = 1'b0;
        w_start        = 1'b0;
        w_abort        = 1'b0;
        w_timeout_fire = 1'b0;
        case (r_state)
            c_st_run: begin
                if (LOAD_USE_HAZARD) begin
                    w_stall = 1'b1;
                end else if (r_valid_id && w_is_divrem && !FLUSH) begin
                    w_start      = 1'b1;
                    w_stall      = 1'b1;
                    w_state_next = c_st_md_wait;
                end else begin
                    w_issue = r_valid_id;
                end
            end
            c_st_md_wait: begin
                w_stall = 1'b1;
                if (FLUSH) begin
                    w_abort      = 1'b1;
                    w_state_next = c_st_run;
                end else if (MULDIV_DONE) begin
                    w_issue      = 1'b1;
                    w_stall      = 1'b0;
                    w_state_next = c_st_run;
                end else if (w_md_expired) begin
                    w_issue        = 1'b1;
                    w_stall        = 1'b0;
                    w_timeout_fire = 1'b1;
                    w_state_next   = c_st_run;
                end
            end
            default: begin
                w_state_next = c_st_run;
            end
        endcase
    end

    // Divider wait counter: cleared on start, counts saturating while waiting
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_md_cnt <= '0;
        end else if (w_start) begin
            r_md_cnt <= '0;
        end else if ((r_state == c_st_md_wait) && (r_md_cnt != c_md_cnt_max)) begin
            r_md_cnt <= r_md_cnt + 1'b1;
        end
    end

    // Sticky divider-timeout flag, cleared only by reset
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_md_error <= 1'b0;
        end else if (w_timeout_fire) begin
            r_md_error <= 1'b1;
        end
    end

    assign INSTRUCTION_ID = r_instr_id;
    assign PC_ID          = r_pc_id;
    assign IMM_SELECT     = w_imm_sel;
    assign OPERAND2_IMM   = w_operand2_imm;
    assign REG_WRITE_EN   = w_issue & w_reg_write;
    assign MEM_READ       = w_issue & w_mem_read;
    assign MEM_WRITE      = w_issue & w_mem_write;
    assign ISSUE          = w_issue;
    assign STALL_IF       = w_stall;
    assign MULDIV_START   = w_start;
    assign MULDIV_ABORT   = w_abort;
    assign ILLEGAL        = r_valid_id & w_illegal;
    assign MD_ERROR       = r_md_error;

endmodule
`default_nettype wire

// File: tb/tb_decode_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_control_unit
// Brief    : Scoreboard bench for decode_control_unit. The driver applies
//            directed and random stimulus, predicts every cycle's outputs
//            and every issued instruction from an instruction-class model,
//            and queues them; a negedge monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_control_unit;

    localparam int          c_md_timeout = 40;
    localparam logic [31:0] c_nop        = 32'h0000_0013;

    logic        CLK;
    logic        RESET;
    logic [31:0] INSTRUCTION_IF;
    logic [31:0] PC_IF;
    logic        IF_VALID;
    logic        FLUSH;
    logic        LOAD_USE_HAZARD;
    logic        MULDIV_DONE;
    logic [31:0] INSTRUCTION_ID;
    logic [31:0] PC_ID;
    logic [2:0]  IMM_SELECT;
    logic        OPERAND2_IMM;
    logic        REG_WRITE_EN;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic        ISSUE;
    logic        STALL_IF;
    logic        MULDIV_START;
    logic        MULDIV_ABORT;
    logic        ILLEGAL;
    logic        MD_ERROR;

    decode_control_unit #(
        .MD_TIMEOUT (c_md_timeout),
        .NOP_INSTR  (c_nop)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .INSTRUCTION_IF  (INSTRUCTION_IF),
        .PC_IF           (PC_IF),
        .IF_VALID        (IF_VALID),
        .FLUSH           (FLUSH),
        .LOAD_USE_HAZARD (LOAD_USE_HAZARD),
        .MULDIV_DONE     (MULDIV_DONE),
        .INSTRUCTION_ID  (INSTRUCTION_ID),
        .PC_ID           (PC_ID),
        .IMM_SELECT      (IMM_SELECT),
        .OPERAND2_IMM    (OPERAND2_IMM),
        .REG_WRITE_EN    (REG_WRITE_EN),
        .MEM_READ        (MEM_READ),
        .MEM_WRITE       (MEM_WRITE),
        .ISSUE           (ISSUE),
        .STALL_IF        (STALL_IF),
        .MULDIV_START    (MULDIV_START),
        .MULDIV_ABORT    (MULDIV_ABORT),
        .ILLEGAL         (ILLEGAL),
        .MD_ERROR        (MD_ERROR)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  imm;
        logic        op2, wr, mr, mw, issue, stall, start, abort, ill, mderr;
    } cyc_exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        wr, mr, mw;
    } iss_t;

    cyc_exp_t exp_q[$];
    iss_t     iss_q[$];
    int       checks = 0;
    int       errors = 0;

    // Reference model state: ID contents plus divider bookkeeping
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_waiting;
    int          m_waited;
    logic        m_err;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic byte cls_of(input logic [6:0] op);
        case (op)
            7'h37, 7'h17:        return "U";
            7'h6F:               return "J";
            7'h67, 7'h03, 7'h13: return "I";
            7'h63:               return "B";
            7'h23:               return "S";
            7'h33:               return "R";
            default:             return "X";
        endcase
    endfunction

    function automatic logic [2:0] imm_of(input byte c);
        case (c)
            "U":     return 3'd0;
            "J":     return 3'd1;
            "I":     return 3'd2;
            "B":     return 3'd3;
            "S":     return 3'd4;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic [31:0] pick_instr();
        case ($urandom_range(16, 0))
            0:       return 32'h000000B7;  // LUI
            1:       return 32'h00001097;  // AUIPC
            2:       return 32'h008000EF;  // JAL
            3:       return 32'h000080E7;  // JALR
            4:       return 32'h0000A083;  // LW
            5:       return 32'h00108093;  // ADDI
            6:       return 32'h00208463;  // BEQ
            7:       return 32'h0020A223;  // SW
            8:       return 32'h002081B3;  // ADD
            9:       return 32'h402081B3;  // SUB
            10:      return 32'h022081B3;  // MUL
            11:      return 32'h022091B3;  // MULH
            12:      return 32'h0220C1B3;  // DIV
            13:      return 32'h0220D1B3;  // DIVU
            14:      return 32'h0220E1B3;  // REM
            15:      return 32'h0000007F;  // unknown opcode
            default: return $urandom;
        endcase
    endfunction

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, expv, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %b expected %b at t=%0t", nm, act, expv, $time);
        end
    endtask

    // Apply one cycle of inputs, predict its outputs, advance the model
    task automatic step(input logic [31:0] ins, input logic [31:0] pc,
                        input logic ifv, input logic fl, input logic hz,
                        input logic dn, input logic rn);
        cyc_exp_t e;
        iss_t     r;
        byte      c;
        logic     div, nxt_wait, nxt_err;
        int       nxt_waited;
        INSTRUCTION_IF  = ins;
        PC_IF           = pc;
        IF_VALID        = ifv;
        FLUSH           = fl;
        LOAD_USE_HAZARD = hz;
        MULDIV_DONE     = dn;
        RESET           = rn;
        if (!rn) begin
            m_instr = c_nop; m_pc = 32'h0; m_valid = 1'b0;
            m_waiting = 1'b0; m_waited = 0; m_err = 1'b0;
        end
        c   = cls_of(m_instr[6:0]);
        div = (m_instr[6:0] == 7'h33) && (m_instr[31:25] == 7'h01) && m_instr[14];
        e.instr = m_instr;
        e.pc    = m_pc;
        e.imm   = imm_of(c);
        e.op2   = (c == "U") || (c == "I") || (c == "S");
        e.issue = 1'b0; e.stall = 1'b0; e.start = 1'b0; e.abort = 1'b0;
        e.ill   = m_valid && (c == "X");
        e.mderr = m_err;
        nxt_wait = m_waiting; nxt_waited = m_waited; nxt_err = m_err;
        if (!m_waiting) begin
            if (hz) begin
                e.stall = 1'b1;
            end else if (m_valid && div && !fl) begin
                e.start = 1'b1; e.stall = 1'b1; nxt_wait = 1'b1; nxt_waited = 0;
            end else begin
                e.issue = m_valid;
            end
        end else begin
            e.stall = 1'b1;
            nxt_waited = m_waited + 1;
            if (fl) begin
                e.abort = 1'b1; nxt_wait = 1'b0;
            end else if (dn) begin
                e.issue = 1'b1; e.stall = 1'b0; nxt_wait = 1'b0;
            end else if (m_waited >= c_md_timeout - 1) begin
                e.issue = 1'b1; e.stall = 1'b0; nxt_wait = 1'b0; nxt_err = 1'b1;
            end
        end
        e.wr = e.issue && !((c == "B") || (c == "S") || (c == "X"));
        e.mr = e.issue && (m_instr[6:0] == 7'h03);
        e.mw = e.issue && (m_instr[6:0] == 7'h23);
        exp_q.push_back(e);
        if (e.issue) begin
            r.instr = m_instr; r.pc = m_pc; r.wr = e.wr; r.mr = e.mr; r.mw = e.mw;
            iss_q.push_back(r);
        end
        if (rn) begin
            if (fl) begin
                m_instr = c_nop; m_valid = 1'b0;
            end else if (!e.stall) begin
                m_instr = ins; m_pc = pc; m_valid = ifv;
            end
            m_waiting = nxt_wait; m_waited = nxt_waited; m_err = nxt_err;
        end
        @(posedge CLK);
        #1;
    endtask

    cyc_exp_t mon_e;
    iss_t     mon_r;

    // Monitor: compare each predicted cycle and each issued instruction
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk32("instruction_id", INSTRUCTION_ID, mon_e.instr);
            chk32("pc_id", PC_ID, mon_e.pc);
            chk32("imm_select", {29'h0, IMM_SELECT}, {29'h0, mon_e.imm});
            chk1("operand2_imm", OPERAND2_IMM, mon_e.op2);
            chk1("reg_write_en", REG_WRITE_EN, mon_e.wr);
            chk1("mem_read", MEM_READ, mon_e.mr);
            chk1("mem_write", MEM_WRITE, mon_e.mw);
            chk1("issue", ISSUE, mon_e.issue);
            chk1("stall_if", STALL_IF, mon_e.stall);
            chk1("muldiv_start", MULDIV_START, mon_e.start);
            chk1("muldiv_abort", MULDIV_ABORT, mon_e.abort);
            chk1("illegal", ILLEGAL, mon_e.ill);
            chk1("md_error", MD_ERROR, mon_e.mderr);
            if (ISSUE === 1'b1) begin
                if (iss_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL issue_unexpected: got ISSUE=1 instr %h expected no issue at t=%0t",
                             INSTRUCTION_ID, $time);
                end else begin
                    mon_r = iss_q.pop_front();
                    chk32("issued_instr", INSTRUCTION_ID, mon_r.instr);
                    chk32("issued_pc", PC_ID, mon_r.pc);
                    chk1("issued_reg_write", REG_WRITE_EN, mon_r.wr);
                    chk1("issued_mem_read", MEM_READ, mon_r.mr);
                    chk1("issued_mem_write", MEM_WRITE, mon_r.mw);
                end
            end
            checks++;
            if (iss_q.size() != 0) begin
                errors++;
                $display("FAIL issue_missing: got ISSUE=%b expected issue of %h at t=%0t",
                         ISSUE, iss_q[0].instr, $time);
                iss_q.delete();
            end
        end
    end

    // Stimulus: directed scenarios first, then randomized traffic
    initial begin
        RESET = 1'b0; INSTRUCTION_IF = 32'h0; PC_IF = 32'h0; IF_VALID = 1'b0;
        FLUSH = 1'b0; LOAD_USE_HAZARD = 1'b0; MULDIV_DONE = 1'b0;
        m_instr = c_nop; m_pc = 32'h0; m_valid = 1'b0;
        m_waiting = 1'b0; m_waited = 0; m_err = 1'b0;
        @(posedge CLK);
        #1;

        // Reset state
        repeat (3) step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // LUI issues one cycle after load
        step(32'h000000B7, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(32'h00000013, 32'h104, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // DIV with DONE five cycles after START
        step(32'h0220C1B3, 32'h108, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(32'h002081B3, 32'h10C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) step(32'h002081B3, 32'h10C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(32'h002081B3, 32'h10C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(32'h00000013, 32'h110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // REM never completes: forced release and sticky error
        step(32'h0220E1B3, 32'h114, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (46) step(32'h00108093, 32'h118, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // FLUSH and DONE together while waiting: abort wins
        step(32'h0220D1B3, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) step(32'h002081B3, 32'h204, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(32'h002081B3, 32'h204, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        step(32'h002081B3, 32'h204, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Store held two cycles by a load-use hazard
        step(32'h0020A223, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(32'h00108093, 32'h304, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(32'h00108093, 32'h304, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(32'h00108093, 32'h304, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(32'h00000013, 32'h308, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Unknown opcode, then reset in the middle of a divide wait
        step(32'h0000007F, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(32'h0220C1B3, 32'h404, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(32'h002081B3, 32'h408, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) step(32'h002081B3, 32'h408, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) step(32'h002081B3, 32'h408, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(32'h002081B3, 32'h408, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Random traffic: frequent DONE first, then sparse DONE/FLUSH to reach timeouts
        for (int p = 0; p < 2; p++) begin
            repeat (2) step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 800; i++) begin
                step(pick_instr(), $urandom,
                     ($urandom_range(7, 0) != 0),
                     (p == 0) ? ($urandom_range(15, 0) == 0) : ($urandom_range(63, 0) == 0),
                     ($urandom_range(5, 0) == 0),
                     (p == 0) ? ($urandom_range(9, 0) == 0) : ($urandom_range(59, 0) == 0),
                     1'b1);
            end
        end

        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute bound on run time
    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before t=500000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
